spi_frame_sequencer: RTL and testbench

//  Controller sitting between the SPI slave and the pitch/yaw PWM generators and encoder path.
//  - Freezes outgoing encoder words (pitch_data/yaw_data) for the whole CS-low window.
//  - Counts SPI clock edges so that only complete 32-bit frames are committed to the PWM command outputs.
//  - Runs a link watchdog that forces safe PWM values when frames stop arriving.

---
 rtl/spi_ctrl_pkg.sv | 27 ++
 rtl/spi_frame_sequencer_if.sv | 28 ++
 rtl/spi_sync2.sv | 23 ++
 rtl/spi_frame_sequencer.sv | 156 +++++++++++++++
 tb/tb_spi_frame_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI frame sequencer: state encoding, counter widths and
// the unsigned clamp used on committed PWM commands.
package spi_ctrl_pkg;

  localparam int unsigned FRAME_BITS_DEF = 32;
  localparam int unsigned CNT_W          = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StActive = ST_ACTIVE,
    StSettle = ST_SETTLE,
    StCommit = ST_COMMIT
  } state_e;

  function automatic logic [15:0] clamp_u16(input logic [15:0] v, input logic [15:0] lo,
                                             input logic [15:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/spi_frame_sequencer_if.sv
// Bus bundle between the SPI slave / encoder path and the frame sequencer.
// The sequencer side uses the slave modport; the driving environment uses master.
interface spi_frame_sequencer_if;
  logic        SPI_CLK;
  logic        SPI_CS;
  logic        enc_valid;
  logic [15:0] enc_pitch;
  logic [15:0] enc_yaw;
  logic [15:0] slv_pitch;
  logic [15:0] slv_yaw;
  logic [15:0] pitch_data;
  logic [15:0] yaw_data;
  logic [15:0] pitch_cmd;
  logic [15:0] yaw_cmd;
  logic        wdog_fault;
  logic [7:0]  frame_ok;
  logic [7:0]  frame_err;

  modport master (
    output SPI_CLK, SPI_CS, enc_valid, enc_pitch, enc_yaw, slv_pitch, slv_yaw,
    input  pitch_data, yaw_data, pitch_cmd, yaw_cmd, wdog_fault, frame_ok, frame_err
  );

  modport slave (
    input  SPI_CLK, SPI_CS, enc_valid, enc_pitch, enc_yaw, slv_pitch, slv_yaw,
    output pitch_data, yaw_data, pitch_cmd, yaw_cmd, wdog_fault, frame_ok, frame_err
  );
endinterface

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for a single asynchronous bit with a configurable reset value.
module spi_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/spi_frame_sequencer.sv
// Commits only complete SPI frames to the PWM command outputs and holds encoder words stable
// while CS is low. Define SPI_CMD_CLAMP_EN to clamp committed commands to [PWM_MIN, PWM_MAX].
module spi_frame_sequencer
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_BITS    = FRAME_BITS_DEF,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned WDOG_CYCLES   = 1000000,
  parameter logic [15:0] SAFE_PITCH    = 16'h0000,
  parameter logic [15:0] SAFE_YAW      = 16'h0000,
  parameter logic [15:0] PWM_MIN       = 16'h0000,
  parameter logic [15:0] PWM_MAX       = 16'hFFFF
) (
  input logic                  clk,
  input logic                  rst,
  spi_frame_sequencer_if.slave bus
);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned WdogW   = $clog2(WDOG_CYCLES + 1);

  logic cs_sync, clk_sync, cs_prev_q, clk_prev_q;
  logic cs_fall, cs_rise, clk_rise;

  spi_sync2 #(.RESET_VAL(1'b1)) u_cs_sync (.clk(clk), .rst(rst), .d(bus.SPI_CS), .q(cs_sync));
  spi_sync2 #(.RESET_VAL(1'b0)) u_clk_sync (.clk(clk), .rst(rst), .d(bus.SPI_CLK), .q(clk_sync));

  assign cs_fall  = cs_prev_q & ~cs_sync;
  assign cs_rise  = ~cs_prev_q & cs_sync;
  assign clk_rise = ~clk_prev_q & clk_sync;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SettleW-1:0]   settle_q, settle_d;
  logic [WdogW-1:0]     wdog_q, wdog_d;
  logic [15:0]          pitch_data_q, pitch_data_d, yaw_data_q, yaw_data_d;
  logic [15:0]          pitch_cmd_q, pitch_cmd_d, yaw_cmd_q, yaw_cmd_d;
  logic                 fault_q, fault_d;
  logic [7:0]           ok_q, ok_d, err_q, err_d;
  logic [15:0]          pitch_new, yaw_new;

`ifdef SPI_CMD_CLAMP_EN
  assign pitch_new = clamp_u16(bus.slv_pitch, PWM_MIN, PWM_MAX);
  assign yaw_new   = clamp_u16(bus.slv_yaw, PWM_MIN, PWM_MAX);
`else
  logic unused_clamp_bounds;
  assign unused_clamp_bounds = ^{PWM_MIN, PWM_MAX};
  assign pitch_new = bus.slv_pitch;
  assign yaw_new   = bus.slv_yaw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_prev_q    <= 1'b1;
      clk_prev_q   <= 1'b0;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      settle_q     <= '0;
      wdog_q       <= '0;
      pitch_data_q <= '0;
      yaw_data_q   <= '0;
      pitch_cmd_q  <= SAFE_PITCH;
      yaw_cmd_q    <= SAFE_YAW;
      fault_q      <= 1'b1;
      ok_q         <= '0;
      err_q        <= '0;
    end else begin
      cs_prev_q    <= cs_sync;
      clk_prev_q   <= clk_sync;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      settle_q     <= settle_d;
      wdog_q       <= wdog_d;
      pitch_data_q <= pitch_data_d;
      yaw_data_q   <= yaw_data_d;
      pitch_cmd_q  <= pitch_cmd_d;
      yaw_cmd_q    <= yaw_cmd_d;
      fault_q      <= fault_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    settle_d     = settle_q;
    wdog_d       = wdog_q;
    pitch_data_d = pitch_data_q;
    yaw_data_d   = yaw_data_q;
    pitch_cmd_d  = pitch_cmd_q;
    yaw_cmd_d    = yaw_cmd_q;
    fault_d      = fault_q;
    ok_d         = ok_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.enc_valid) begin
          pitch_data_d = bus.enc_pitch;
          yaw_data_d   = bus.enc_yaw;
        end
        if (cs_fall) begin
          bit_cnt_d = '0;
          state_d   = StActive;
        end
      end
      StActive: begin
        if (clk_rise && (bit_cnt_q != '1)) bit_cnt_d = bit_cnt_q + 1'b1;
        if (cs_rise) begin
          settle_d = '0;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        // CS edges seen here are dropped; a frame restarting this early is lost.
        if (settle_q == SettleW'(SETTLE_CYCLES - 1)) begin
          if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
            state_d = StCommit;
          end else begin
            err_d   = err_q + 8'd1;
            state_d = StIdle;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StCommit: begin
        pitch_cmd_d = pitch_new;
        yaw_cmd_d   = yaw_new;
        ok_d        = ok_q + 8'd1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Commit outranks expiry in the same cycle.
    if (state_q == StCommit) begin
      wdog_d  = '0;
      fault_d = 1'b0;
    end else if (wdog_q == WdogW'(WDOG_CYCLES - 1)) begin
      fault_d     = 1'b1;
      pitch_cmd_d = SAFE_PITCH;
      yaw_cmd_d   = SAFE_YAW;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  assign bus.pitch_data = pitch_data_q;
  assign bus.yaw_data   = yaw_data_q;
  assign bus.pitch_cmd  = pitch_cmd_q;
  assign bus.yaw_cmd    = yaw_cmd_q;
  assign bus.wdog_fault = fault_q;
  assign bus.frame_ok   = ok_q;
  assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed bench for spi_frame_sequencer (watchdog shortened to 100 cycles, PWM_MAX = 0x8000).
module tb_spi_frame_sequencer;
  import spi_ctrl_pkg::*;

`ifdef SPI_CMD_CLAMP_EN
  localparam logic [15:0] EXP_BEEF = 16'h8000;
  localparam logic [15:0] EXP_DEAD = 16'h8000;
`else
  localparam logic [15:0] EXP_BEEF = 16'hBEEF;
  localparam logic [15:0] EXP_DEAD = 16'hDEAD;
`endif

  logic clk, rst;
  int   n_cmp, n_bad;

  spi_frame_sequencer_if bus ();

  spi_frame_sequencer #(
    .FRAME_BITS   (32),
    .SETTLE_CYCLES(4),
    .WDOG_CYCLES  (100),
    .SAFE_PITCH   (16'h0000),
    .SAFE_YAW     (16'h0000),
    .PWM_MIN      (16'h0000),
    .PWM_MAX      (16'h8000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cs_low();
    bus.SPI_CS = 1'b0;
  endtask

  task automatic cs_high();
    bus.SPI_CS = 1'b1;
  endtask

  task automatic clock_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bus.SPI_CLK = 1'b1;
      repeat (5) @(negedge clk);
      bus.SPI_CLK = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int n);
    cs_low();
    repeat (8) @(negedge clk);
    clock_bits(n);
    repeat (2) @(negedge clk);
    cs_high();
  endtask

  task automatic pulse_enc(input logic [15:0] p, input logic [15:0] y);
    bus.enc_pitch = p;
    bus.enc_yaw   = y;
    bus.enc_valid = 1'b1;
    @(negedge clk);
    bus.enc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.SPI_CS = 1'b1; bus.SPI_CLK = 1'b0; bus.enc_valid = 1'b0;
    bus.enc_pitch = '0; bus.enc_yaw = '0; bus.slv_pitch = '0; bus.slv_yaw = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.pitch_data !== 16'h0000) begin n_bad++;
      $display("FAIL rst_pitch_data: got %h want 0000", bus.pitch_data); end
    n_cmp++; if (bus.yaw_data !== 16'h0000) begin n_bad++;
      $display("FAIL rst_yaw_data: got %h want 0000", bus.yaw_data); end
    n_cmp++; if (bus.pitch_cmd !== 16'h0000) begin n_bad++;
      $display("FAIL rst_pitch_cmd: got %h want 0000", bus.pitch_cmd); end
    n_cmp++; if (bus.yaw_cmd !== 16'h0000) begin n_bad++;
      $display("FAIL rst_yaw_cmd: got %h want 0000", bus.yaw_cmd); end
    n_cmp++; if (bus.wdog_fault !== 1'b1) begin n_bad++;
      $display("FAIL rst_fault: got %b want 1", bus.wdog_fault); end
    n_cmp++; if (bus.frame_ok !== 8'd0 || bus.frame_err !== 8'd0) begin n_bad++;
      $display("FAIL rst_counts: got ok=%0d err=%0d want 0/0", bus.frame_ok, bus.frame_err); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.wdog_fault !== 1'b1 || bus.pitch_cmd !== 16'h0000 || bus.frame_ok !== 8'd0)
    begin n_bad++; $display("FAIL idle_after_rst: got fault=%b cmd=%h ok=%0d want 1/0000/0",
      bus.wdog_fault, bus.pitch_cmd, bus.frame_ok); end
  endtask

  task automatic test_commit();
    bus.slv_pitch = 16'hBEEF; bus.slv_yaw = 16'hDEAD;
    send_frame(32);
    repeat (7) @(negedge clk);
    n_cmp++; if (bus.pitch_cmd !== 16'h0000 || bus.frame_ok !== 8'd0) begin n_bad++;
      $display("FAIL commit_early: got cmd=%h ok=%0d want 0000/0", bus.pitch_cmd, bus.frame_ok); end
    @(negedge clk);
    n_cmp++; if (bus.pitch_cmd !== EXP_BEEF) begin n_bad++;
      $display("FAIL commit_pitch: got %h want %h", bus.pitch_cmd, EXP_BEEF); end
    n_cmp++; if (bus.yaw_cmd !== EXP_DEAD) begin n_bad++;
      $display("FAIL commit_yaw: got %h want %h", bus.yaw_cmd, EXP_DEAD); end
    n_cmp++; if (bus.wdog_fault !== 1'b0 || bus.frame_ok !== 8'd1) begin n_bad++;
      $display("FAIL commit_status: got fault=%b ok=%0d want 0/1", bus.wdog_fault, bus.frame_ok); end
  endtask

  task automatic test_enc_freeze();
    pulse_enc(16'h1111, 16'h2222);
    n_cmp++; if (bus.pitch_data !== 16'h1111 || bus.yaw_data !== 16'h2222) begin n_bad++;
      $display("FAIL enc_idle_load: got %h/%h want 1111/2222", bus.pitch_data, bus.yaw_data); end
    bus.slv_pitch = 16'h0102; bus.slv_yaw = 16'h0304;
    cs_low();
    repeat (6) @(negedge clk);
    pulse_enc(16'h1234, 16'h5678);
    n_cmp++; if (bus.pitch_data !== 16'h1111 || bus.yaw_data !== 16'h2222) begin n_bad++;
      $display("FAIL enc_frozen: got %h/%h want 1111/2222", bus.pitch_data, bus.yaw_data); end
    clock_bits(32);
    cs_high();
    repeat (12) @(negedge clk);
    n_cmp++; if (bus.pitch_data !== 16'h1111) begin n_bad++;
      $display("FAIL enc_not_latched_late: got %h want 1111", bus.pitch_data); end
    n_cmp++; if (bus.pitch_cmd !== 16'h0102 || bus.yaw_cmd !== 16'h0304 || bus.frame_ok !== 8'd2)
    begin n_bad++; $display("FAIL enc_frame_commit: got %h/%h ok=%0d want 0102/0304/2",
      bus.pitch_cmd, bus.yaw_cmd, bus.frame_ok); end
    pulse_enc(16'h1234, 16'h5678);
    n_cmp++; if (bus.pitch_data !== 16'h1234 || bus.yaw_data !== 16'h5678) begin n_bad++;
      $display("FAIL enc_reload: got %h/%h want 1234/5678", bus.pitch_data, bus.yaw_data); end
  endtask

  task automatic test_bad_length();
    bus.slv_pitch = 16'hAAAA; bus.slv_yaw = 16'h5555;
    send_frame(24);
    repeat (12) @(negedge clk);
    n_cmp++; if (bus.frame_err !== 8'd1 || bus.frame_ok !== 8'd2) begin n_bad++;
      $display("FAIL short_frame: got err=%0d ok=%0d want 1/2", bus.frame_err, bus.frame_ok); end
    // The 24-bit frame outlasts the 100-cycle watchdog, so commands sit at SAFE.
    n_cmp++; if (bus.pitch_cmd !== 16'h0000 || bus.wdog_fault !== 1'b1) begin n_bad++;
      $display("FAIL short_no_commit: got cmd=%h fault=%b want 0000/1",
        bus.pitch_cmd, bus.wdog_fault); end
    send_frame(40);
    repeat (12) @(negedge clk);
    n_cmp++; if (bus.frame_err !== 8'd2 || bus.frame_ok !== 8'd2 || bus.pitch_cmd !== 16'h0000)
    begin n_bad++; $display("FAIL long_frame: got err=%0d ok=%0d cmd=%h want 2/2/0000",
      bus.frame_err, bus.frame_ok, bus.pitch_cmd); end
  endtask

  task automatic test_watchdog();
    bit seen;
    bus.slv_pitch = 16'h1357; bus.slv_yaw = 16'h2468;
    send_frame(32);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_ok == 8'd3) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++;
      $display("FAIL wdog_commit_timeout: got ok=%0d want 3", bus.frame_ok); end
    n_cmp++; if (bus.pitch_cmd !== 16'h1357 || bus.wdog_fault !== 1'b0) begin n_bad++;
      $display("FAIL wdog_start: got cmd=%h fault=%b want 1357/0", bus.pitch_cmd, bus.wdog_fault); end
    repeat (99) @(negedge clk);
    n_cmp++; if (bus.wdog_fault !== 1'b0 || bus.pitch_cmd !== 16'h1357) begin n_bad++;
      $display("FAIL wdog_99: got fault=%b cmd=%h want 0/1357", bus.wdog_fault, bus.pitch_cmd); end
    @(negedge clk);
    n_cmp++; if (bus.wdog_fault !== 1'b1 || bus.pitch_cmd !== 16'h0000 || bus.yaw_cmd !== 16'h0000)
    begin n_bad++; $display("FAIL wdog_100: got fault=%b cmd=%h/%h want 1/0000/0000",
      bus.wdog_fault, bus.pitch_cmd, bus.yaw_cmd); end
    bus.slv_pitch = 16'h0F0F; bus.slv_yaw = 16'h7070;
    send_frame(32);
    repeat (12) @(negedge clk);
    n_cmp++; if (bus.wdog_fault !== 1'b0 || bus.pitch_cmd !== 16'h0F0F || bus.yaw_cmd !== 16'h7070
                 || bus.frame_ok !== 8'd4)
    begin n_bad++; $display("FAIL wdog_recover: got fault=%b cmd=%h/%h ok=%0d want 0/0F0F/7070/4",
      bus.wdog_fault, bus.pitch_cmd, bus.yaw_cmd, bus.frame_ok); end
  endtask

  task automatic test_settle_refall();
    bus.slv_pitch = 16'h4444; bus.slv_yaw = 16'h4444;
    send_frame(32);
    repeat (4) @(negedge clk);
    cs_low();
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.pitch_cmd !== 16'h4444 || bus.frame_ok !== 8'd5) begin n_bad++;
      $display("FAIL refall_commit: got cmd=%h ok=%0d want 4444/5", bus.pitch_cmd, bus.frame_ok); end
    bus.slv_pitch = 16'h9999; bus.slv_yaw = 16'h9999;
    clock_bits(32);
    cs_high();
    repeat (12) @(negedge clk);
    n_cmp++; if (bus.frame_ok !== 8'd5 || bus.pitch_cmd !== 16'h0000 || bus.wdog_fault !== 1'b1)
    begin n_bad++; $display("FAIL refall_lost: got ok=%0d cmd=%h fault=%b want 5/0000/1",
      bus.frame_ok, bus.pitch_cmd, bus.wdog_fault); end
    bus.slv_pitch = 16'h0A0A; bus.slv_yaw = 16'h0B0B;
    send_frame(32);
    repeat (12) @(negedge clk);
    n_cmp++; if (bus.frame_ok !== 8'd6 || bus.pitch_cmd !== 16'h0A0A || bus.wdog_fault !== 1'b0)
    begin n_bad++; $display("FAIL refall_next: got ok=%0d cmd=%h fault=%b want 6/0A0A/0",
      bus.frame_ok, bus.pitch_cmd, bus.wdog_fault); end
  endtask

  task automatic test_err_wrap();
    for (int i = 0; i < 253; i++) begin
      send_frame(0);
      repeat (10) @(negedge clk);
    end
    n_cmp++; if (bus.frame_err !== 8'd255) begin n_bad++;
      $display("FAIL err_255: got %0d want 255", bus.frame_err); end
    send_frame(0);
    repeat (10) @(negedge clk);
    n_cmp++; if (bus.frame_err !== 8'd0 || bus.frame_ok !== 8'd6) begin n_bad++;
      $display("FAIL err_wrap: got err=%0d ok=%0d want 0/6", bus.frame_err, bus.frame_ok); end
  endtask

  task automatic test_reset_midframe();
    bus.slv_pitch = 16'hFFFF; bus.slv_yaw = 16'hFFFF;
    cs_low();
    repeat (8) @(negedge clk);
    clock_bits(16);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.frame_ok !== 8'd0 || bus.frame_err !== 8'd0 || bus.wdog_fault !== 1'b1
                 || bus.pitch_cmd !== 16'h0000)
    begin n_bad++; $display("FAIL midframe_rst: got ok=%0d err=%0d fault=%b cmd=%h want 0/0/1/0000",
      bus.frame_ok, bus.frame_err, bus.wdog_fault, bus.pitch_cmd); end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    clock_bits(16);
    cs_high();
    repeat (12) @(negedge clk);
    n_cmp++; if (bus.frame_err !== 8'd1 || bus.frame_ok !== 8'd0) begin n_bad++;
      $display("FAIL cs_low_at_release: got err=%0d ok=%0d want 1/0", bus.frame_err, bus.frame_ok); end
    n_cmp++; if (bus.pitch_cmd !== 16'h0000 || bus.wdog_fault !== 1'b1) begin n_bad++;
      $display("FAIL cs_low_no_commit: got cmd=%h fault=%b want 0000/1",
        bus.pitch_cmd, bus.wdog_fault); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_commit();
    test_enc_freeze();
    test_bad_length();
    test_watchdog();
    test_settle_refall();
    test_err_wrap();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
